// File: rtl/decode_stage.sv
// RV32I decode stage: decodes a full instruction word into a registered control bundle
// behind a valid/ready pipeline register, with load-use bubbles, flush and a stall counter.
module decode_stage #(
    parameter bit EN_MEXT = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             reg_wr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             alu_s1,
    output logic             alu_s2,
    output logic             jump_ctrl,
    output logic             do_branch,
    output logic             illegal,
    output logic [1:0]       wb_ctrl,
    output logic [4:0]       alu_op,
    output logic [2:0]       branch_ctrl,
    output logic [2:0]       mem_ctrl,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [CNT_W-1:0] stall_cnt
);

    // Handshake: a side transfers on every cycle where its valid and ready are both high;
    // an offered bundle stays stable until out_ready, and a flush cycle swallows any input.

    typedef struct packed {
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       alu_s1;
        logic       alu_s2;
        logic       jump_ctrl;
        logic       do_branch;
        logic       illegal;
        logic [1:0] wb_ctrl;
        logic [4:0] alu_op;
        logic [2:0] branch_ctrl;
        logic [2:0] mem_ctrl;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } bundle_t;

    localparam logic [CNT_W-1:0] STALL_MAX = '1;
    localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [6:0] opcode;
    logic [6:0] f7;
    logic [2:0] f3;
    bundle_t    raw;
    bundle_t    dec;
    bundle_t    bundle_q;
    logic       use_rs1;
    logic       use_rs2;
    logic       bad;
    logic       last_load_valid;
    logic [4:0] last_load_rd;
    logic       hazard;
    logic       accept;
    logic       out_fire;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    always_comb begin
        raw     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        bad     = 1'b0;
        case (opcode)
            7'b0110011: begin
                raw.reg_wr  = 1'b1;
                raw.wb_ctrl = 2'b01;
                raw.alu_s1  = 1'b1;
                raw.alu_s2  = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                if (f7 == 7'b0000000)
                    raw.alu_op = {2'b00, f3};
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    raw.alu_op = {2'b01, f3};
                else if (f7 == 7'b0000001 && EN_MEXT)
                    raw.alu_op = {2'b10, f3};
                else
                    bad = 1'b1;
            end
            7'b0010011: begin
                raw.reg_wr  = 1'b1;
                raw.wb_ctrl = 2'b01;
                raw.alu_s1  = 1'b1;
                use_rs1     = 1'b1;
                raw.alu_op  = {2'b00, f3};
                // Shift-immediates carry the arithmetic/logical selector in bit 30.
                if (f3 == 3'b101)
                    raw.alu_op[3] = in_inst[30];
                if (f3 == 3'b001 && f7 != 7'b0000000)
                    bad = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
                    bad = 1'b1;
            end
            7'b0000011: begin
                raw.reg_wr = 1'b1;
                raw.mem_rd = 1'b1;
                raw.alu_s1 = 1'b1;
                use_rs1    = 1'b1;
                case (f3)
                    3'b000:  raw.mem_ctrl = 3'b000;
                    3'b001:  raw.mem_ctrl = 3'b001;
                    3'b010:  raw.mem_ctrl = 3'b010;
                    3'b100:  raw.mem_ctrl = 3'b011;
                    3'b101:  raw.mem_ctrl = 3'b100;
                    default: bad = 1'b1;
                endcase
            end
            7'b0100011: begin
                raw.mem_wr = 1'b1;
                raw.alu_s1 = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                case (f3)
                    3'b000:  raw.mem_ctrl = 3'b101;
                    3'b001:  raw.mem_ctrl = 3'b110;
                    3'b010:  raw.mem_ctrl = 3'b111;
                    default: bad = 1'b1;
                endcase
            end
            7'b1100011: begin
                raw.do_branch   = 1'b1;
                raw.branch_ctrl = f3;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                if (f3 == 3'b010 || f3 == 3'b011)
                    bad = 1'b1;
            end
            7'b0110111: begin
                raw.reg_wr  = 1'b1;
                raw.wb_ctrl = 2'b11;
            end
            7'b0010111: begin
                raw.reg_wr  = 1'b1;
                raw.wb_ctrl = 2'b01;
            end
            7'b1101111: begin
                raw.reg_wr    = 1'b1;
                raw.wb_ctrl   = 2'b10;
                raw.jump_ctrl = 1'b1;
            end
            7'b1100111: begin
                raw.reg_wr    = 1'b1;
                raw.wb_ctrl   = 2'b10;
                raw.jump_ctrl = 1'b1;
                raw.alu_s1    = 1'b1;
                use_rs1       = 1'b1;
                if (f3 != 3'b000)
                    bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        raw.rd  = raw.reg_wr ? in_inst[11:7] : 5'd0;
        raw.rs1 = use_rs1 ? in_inst[19:15] : 5'd0;
        raw.rs2 = use_rs2 ? in_inst[24:20] : 5'd0;
        // An illegal word travels as an inert bundle: no enables and no register uses.
        dec = raw;
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Unused index fields decode to 0 and last_load_rd is never 0 while valid, so x0 never matches.
    assign hazard   = last_load_valid & in_valid & ~flush &
                      ((dec.rs1 == last_load_rd) | (dec.rs2 == last_load_rd));
    assign in_ready = flush | (~hazard & (~out_valid | out_ready));
    assign accept   = in_valid & in_ready & ~flush;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            bundle_q        <= '0;
            last_load_valid <= 1'b0;
            last_load_rd    <= 5'd0;
            stall_cnt       <= '0;
        end else begin
            if (flush) begin
                out_valid       <= 1'b0;
                last_load_valid <= 1'b0;
                last_load_rd    <= 5'd0;
            end else begin
                last_load_valid <= out_fire & bundle_q.mem_rd & (bundle_q.rd != 5'd0);
                last_load_rd    <= bundle_q.rd;
                if (accept) begin
                    out_valid <= 1'b1;
                    bundle_q  <= dec;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
            if (hazard && stall_cnt != STALL_MAX)
                stall_cnt <= stall_cnt + STALL_ONE;
        end
    end

    assign reg_wr      = bundle_q.reg_wr;
    assign mem_rd      = bundle_q.mem_rd;
    assign mem_wr      = bundle_q.mem_wr;
    assign alu_s1      = bundle_q.alu_s1;
    assign alu_s2      = bundle_q.alu_s2;
    assign jump_ctrl   = bundle_q.jump_ctrl;
    assign do_branch   = bundle_q.do_branch;
    assign illegal     = bundle_q.illegal;
    assign wb_ctrl     = bundle_q.wb_ctrl;
    assign alu_op      = bundle_q.alu_op;
    assign branch_ctrl = bundle_q.branch_ctrl;
    assign mem_ctrl    = bundle_q.mem_ctrl;
    assign rd          = bundle_q.rd;
    assign rs1         = bundle_q.rs1;
    assign rs2         = bundle_q.rs2;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios plus randomized traffic checked
// against a rule-level reference of the decode table, handshake and load-use behaviour.
module tb_decode_stage;
    localparam int CNT_W = 4;
    localparam int BW    = 36;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_LW5  = 32'h0000A283;
    localparam logic [31:0] I_LW0  = 32'h0000A003;
    localparam logic [31:0] I_ADD6 = 32'h00228333;
    localparam logic [31:0] I_ADD0 = 32'h00200333;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_inst = 32'd0;
    logic        in_ready, out_valid;
    logic        reg_wr, mem_rd, mem_wr, alu_s1, alu_s2, jump_ctrl, do_branch, illegal;
    logic [1:0]  wb_ctrl;
    logic [4:0]  alu_op, rd, rs1, rs2;
    logic [2:0]  branch_ctrl, mem_ctrl;
    logic [CNT_W-1:0] stall_cnt;
    logic [BW-1:0]    dut_bundle;

    decode_stage #(.EN_MEXT(1'b1), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_s1(alu_s1), .alu_s2(alu_s2),
        .jump_ctrl(jump_ctrl), .do_branch(do_branch), .illegal(illegal), .wb_ctrl(wb_ctrl),
        .alu_op(alu_op), .branch_ctrl(branch_ctrl), .mem_ctrl(mem_ctrl),
        .rd(rd), .rs1(rs1), .rs2(rs2), .stall_cnt(stall_cnt)
    );

    assign dut_bundle = {reg_wr, mem_rd, mem_wr, alu_s1, alu_s2, jump_ctrl, do_branch, illegal,
                         wb_ctrl, alu_op, branch_ctrl, mem_ctrl, rd, rs1, rs2};

    // second instance without the M extension, driven directly
    logic        d0_in_valid = 1'b0;
    logic [31:0] d0_in_inst = 32'd0;
    logic        d0_in_ready, d0_out_valid;
    logic        d0_reg_wr, d0_mem_rd, d0_mem_wr, d0_alu_s1, d0_alu_s2, d0_jump, d0_branch, d0_illegal;
    logic [1:0]  d0_wb_ctrl;
    logic [4:0]  d0_alu_op, d0_rd, d0_rs1, d0_rs2;
    logic [2:0]  d0_branch_ctrl, d0_mem_ctrl;
    logic [15:0] d0_stall_cnt;

    decode_stage #(.EN_MEXT(1'b0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .in_inst(d0_in_inst), .out_valid(d0_out_valid), .out_ready(1'b1),
        .reg_wr(d0_reg_wr), .mem_rd(d0_mem_rd), .mem_wr(d0_mem_wr), .alu_s1(d0_alu_s1),
        .alu_s2(d0_alu_s2), .jump_ctrl(d0_jump), .do_branch(d0_branch), .illegal(d0_illegal),
        .wb_ctrl(d0_wb_ctrl), .alu_op(d0_alu_op), .branch_ctrl(d0_branch_ctrl),
        .mem_ctrl(d0_mem_ctrl), .rd(d0_rd), .rs1(d0_rs1), .rs2(d0_rs2), .stall_cnt(d0_stall_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Reference decode: bundle layout {enables(8), wb, alu_op, branch, mem, rd, rs1, rs2}
    function automatic logic [BW-1:0] ref_decode(input logic [31:0] i, input bit mext);
        logic [6:0] op = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        bit wr = 0, mr = 0, mw = 0, s1 = 0, s2 = 0, j = 0, br = 0, u1 = 0, u2 = 0, ok = 1;
        logic [1:0] wb = 2'd0;
        logic [4:0] aop = 5'd0;
        logic [2:0] bc = 3'd0, mc = 3'd0;
        case (op)
            7'h33: begin
                wr = 1; wb = 2'd1; s1 = 1; s2 = 1; u1 = 1; u2 = 1;
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                     (f7 == 7'h01 && mext);
                aop = 5'(f3) + ((f7 == 7'h01) ? 5'd16 : (f7 == 7'h20) ? 5'd8 : 5'd0);
            end
            7'h13: begin
                wr = 1; wb = 2'd1; s1 = 1; u1 = 1;
                aop = 5'(f3) + ((f3 == 3'd5 && i[30]) ? 5'd8 : 5'd0);
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
            end
            7'h03: begin
                wr = 1; mr = 1; s1 = 1; u1 = 1;
                case (f3)
                    3'd0: mc = 3'd0;
                    3'd1: mc = 3'd1;
                    3'd2: mc = 3'd2;
                    3'd4: mc = 3'd3;
                    3'd5: mc = 3'd4;
                    default: ok = 0;
                endcase
            end
            7'h23: begin
                mw = 1; s1 = 1; u1 = 1; u2 = 1;
                ok = (f3 < 3'd3);
                mc = 3'd5 + f3;
            end
            7'h63: begin
                br = 1; bc = f3; u1 = 1; u2 = 1;
                ok = !(f3 == 3'd2 || f3 == 3'd3);
            end
            7'h37: begin wr = 1; wb = 2'd3; end
            7'h17: begin wr = 1; wb = 2'd1; end
            7'h6F: begin wr = 1; wb = 2'd2; j = 1; end
            7'h67: begin wr = 1; wb = 2'd2; j = 1; s1 = 1; u1 = 1; ok = (f3 == 3'd0); end
            default: ok = 0;
        endcase
        if (!ok) return {8'b0000_0001, 28'd0};
        return {wr, mr, mw, s1, s2, j, br, 1'b0, wb, aop, bc, mc,
                wr ? i[11:7] : 5'd0, u1 ? i[19:15] : 5'd0, u2 ? i[24:20] : 5'd0};
    endfunction

    function automatic bit ref_uses(input logic [31:0] i, input logic [4:0] r);
        logic [BW-1:0] b = ref_decode(i, 1'b1);
        return (b[9:5] == r) || (b[4:0] == r);
    endfunction

    // scoreboard state
    logic [BW-1:0]    exp_q[$];
    logic [4:0]       m_llr = 5'd0;
    logic [CNT_W-1:0] m_stall = '0;
    bit               acc_pend = 0;
    bit               consumed = 0;
    logic [31:0]      pend_inst = 32'd0;

    // monitor: compares handshake, counter and the presented bundle every cycle
    always @(negedge clk) begin
        bit haz, exp_ir, occ;
        logic [BW-1:0] b;
        logic [4:0] next_llr;
        if (rst) begin
            exp_q.delete();
            m_llr = 5'd0; m_stall = '0; acc_pend = 0; consumed = 0;
        end else begin
            occ    = (exp_q.size() != 0);
            haz    = !flush && in_valid && m_llr != 5'd0 && ref_uses(in_inst, m_llr);
            exp_ir = flush || (!haz && (!occ || out_ready));
            check("out_valid", out_valid, occ);
            check("in_ready", in_ready, exp_ir);
            check("stall_cnt", stall_cnt, m_stall);
            next_llr = 5'd0;
            if (occ) begin
                b = exp_q[0];
                check("bundle", dut_bundle, b);
                if (out_ready && !flush) begin
                    void'(exp_q.pop_front());
                    if (b[34] && b[14:10] != 5'd0) next_llr = b[14:10];
                end
            end
            if (flush) exp_q.delete();
            if (haz && m_stall != '1) m_stall = m_stall + 1'b1;
            m_llr     = next_llr;
            acc_pend  = in_valid && exp_ir && !flush;
            consumed  = in_valid && exp_ir;
            pend_inst = in_inst;
        end
    end

    // expected bundle enters the queue on the edge that accepts it
    always @(posedge clk) begin
        if (!rst && acc_pend) exp_q.push_back(ref_decode(pend_inst, 1'b1));
    end

    // driver tasks: each starts and ends at a rising edge, inputs change 1 time unit later
    function automatic logic rand_ready();
        return ($urandom_range(0, 9) < 7);
    endfunction

    function automatic logic [31:0] rand_inst();
        int s = $urandom_range(0, 10);
        logic [6:0] op;
        logic [6:0] f7;
        case (s)
            0: op = 7'h33;  1: op = 7'h13;  2, 3: op = 7'h03;  4: op = 7'h23;  5: op = 7'h63;
            6: op = 7'h37;  7: op = 7'h17;  8: op = 7'h6F;     9: op = 7'h67;
            default: op = 7'($urandom);
        endcase
        case ($urandom_range(0, 4))
            0, 1: f7 = 7'h00;
            2: f7 = 7'h20;
            3: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), op};
    endfunction

    task automatic send(input logic [31:0] inst, input int mode);
        #1;
        flush = 0; in_valid = 1; in_inst = inst;
        out_ready = (mode == 2) ? rand_ready() : (mode == 1);
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            if (consumed) break;
            if (mode == 2) begin
                #1 out_ready = rand_ready();
            end
        end
        check("accept_in_time", consumed, 1);
    endtask

    task automatic idle(input int n, input logic ordy);
        repeat (n) begin
            #1;
            flush = 0; in_valid = 0; out_ready = ordy;
            @(posedge clk);
        end
    endtask

    task automatic flush_cycle(input logic v, input logic [31:0] inst, input logic ordy);
        #1;
        flush = 1; in_valid = v; in_inst = inst; out_ready = ordy;
        @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #7;
        check("reset_out_valid", out_valid, 0);
        check("reset_bundle", dut_bundle, '0);
        check("reset_stall", stall_cnt, 0);
        check("reset_d0_valid", d0_out_valid, 0);
        #5 rst = 0;
        @(posedge clk);

        // M extension disabled: mul is illegal, plain add decodes normally
        #1 d0_in_valid = 1; d0_in_inst = I_MUL;
        @(posedge clk); #1 d0_in_valid = 0;
        @(negedge clk);
        check("d0_mul_valid", d0_out_valid, 1);
        check("d0_mul_illegal", d0_illegal, 1);
        check("d0_mul_reg_wr", d0_reg_wr, 0);
        check("d0_mul_rd", d0_rd, 0);
        #1 d0_in_valid = 1; d0_in_inst = I_ADD;
        @(posedge clk); #1 d0_in_valid = 0;
        @(negedge clk);
        check("d0_add_illegal", d0_illegal, 0);
        check("d0_add_alu_op", d0_alu_op, 0);
        check("d0_add_rd", d0_rd, 3);
        @(posedge clk);

        // back-to-back add / sub
        send(I_ADD, 1); send(I_SUB, 1); idle(3, 1);
        // load-use bubble, then the same with rd = x0
        send(I_LW5, 1); idle(1, 1); send(I_ADD6, 1); idle(3, 1);
        send(I_LW0, 1); idle(1, 1); send(I_ADD0, 1); idle(3, 1);
        // back-pressure for three cycles, then transfer and accept together
        send(I_ADD, 0);
        #1 in_valid = 1; in_inst = I_SUB; out_ready = 0;
        repeat (3) @(posedge clk);
        send(I_SUB, 1); idle(2, 1);
        // mul with M extension, unknown opcode
        send(I_MUL, 1); send(32'h0000007F, 1); idle(2, 1);
        // flush drops held bundle and the incoming word
        send(I_ADD, 0); flush_cycle(1, I_SUB, 0); idle(2, 1);
        // flush while a load leaves: no hazard on the following dependent add
        send(I_LW5, 0); flush_cycle(0, 32'd0, 1); send(I_ADD6, 1); idle(2, 1);
        // saturate the stall counter
        for (int n = 0; n < (1 << CNT_W) + 2; n++) begin
            send(I_LW5, 1); idle(1, 1); send(I_ADD6, 1);
        end
        idle(1, 1);
        @(negedge clk);
        check("stall_saturated", stall_cnt, 4'hF);
        @(posedge clk);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 6) flush_cycle(1'($urandom_range(0, 1)), rand_inst(), rand_ready());
            else if (r < 18) idle(1, rand_ready());
            else send(rand_inst(), 2);
        end
        idle(3, 1);

        // asynchronous reset while a bundle is held
        send(I_ADD, 0);
        #3;
        rst = 1; in_valid = 0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_bundle", dut_bundle, '0);
        check("async_rst_stall", stall_cnt, 0);
        @(negedge clk);
        #2 rst = 0;
        @(posedge clk);
        send(I_ADD, 1); send(I_LW5, 1); idle(1, 1); send(I_ADD6, 1); idle(3, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I decode/control stage between fetch and execute; successor to the combinational controller.
- Decodes the full 32-bit instruction into the control bundle and captures it in a pipeline register with valid/ready handshakes.
- Adds load-use hazard bubbles, flush, illegal-instruction flagging, a parametrised M-extension mode and a stall performance counter.

Parameters:
- EN_MEXT, 0, 1 = decode MUL/DIV (opcode 0110011, f7 0000001); 0 = such encodings are illegal.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  drop the held and incoming instruction
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- out_valid  out  1  bundle valid
- out_ready  in  1  execute accepts the bundle
- reg_wr, mem_rd, mem_wr, alu_s1, alu_s2, jump_ctrl, do_branch, illegal  out  1 each  control bits
- wb_ctrl  out  2  00 mem, 01 alu, 10 pc+4, 11 immediate (LUI)
- alu_op  out  5  ALU operation
- branch_ctrl, mem_ctrl  out  3 each  branch condition / memory size code
- rd, rs1, rs2  out  5 each  register indices
- stall_cnt  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, rst=1): every registered output and internal register goes to 0 immediately, including out_valid, the whole bundle, last_load_valid, last_load_rd and stall_cnt. No X ever appears on outputs; unused fields are driven 0.
- Decode (combinational, fields f3=inst[14:12], f7=inst[31:25]):
  - R (0110011): reg_wr 1, wb 01, s1 1, s2 1.
    - f7=0: alu_op {0,0,f3}.
    - f7=0100000 with f3 000/101: alu_op {0,1,f3}.
    - f7=0000001 with EN_MEXT=1: alu_op {1,0,f3}.
    - Any other f7/f3 combination: illegal.
  - I-ALU (0010011): reg_wr 1, wb 01, s1 1, s2 0, alu_op {0,0,f3}.
    - f3=101: alu_op bit3 = inst[30].
    - f3=001 needs f7=0; f3=101 needs f7 0 or 0100000; otherwise illegal.
  - Load (0000011): reg_wr, mem_rd, wb 00, s1 1, s2 0, alu_op 0, mem_ctrl LB000 LH001 LW010 LBU011 LHU100; other f3 illegal.
  - Store (0100011): mem_wr 1, s1 1, s2 0, alu_op 0, mem_ctrl SB101 SH110 SW111; other f3 illegal.
  - Branch (1100011): do_branch 1, branch_ctrl=f3, s1 0, s2 0, mem_wr 0; f3 010/011 illegal.
  - LUI (0110111): reg_wr, wb 11.
  - AUIPC (0010111): reg_wr, wb 01, s1 0, s2 0, alu_op 0.
  - JAL (1101111): reg_wr, wb 10, jump 1, s1 0, s2 0.
  - JALR (1100111, f3 000): reg_wr, wb 10, jump 1, s1 1, s2 0.
  - Anything else: illegal.
- Illegal instructions still flow down the pipe with illegal=1 and all enables (reg_wr, mem_rd, mem_wr, jump_ctrl, do_branch) forced 0.
- Register uses:
  - rs1 used by R, I-ALU, load, store, branch, JALR.
  - rs2 used by R, store, branch.
  - Unused index fields output as 0.
  - rd output 0 when reg_wr=0.
- Load-use hazard:
  - When a load bundle with rd≠0 transfers (out_valid & out_ready), set last_load_valid=1 and last_load_rd=rd for exactly the next cycle.
  - If in that cycle in_valid=1 and the incoming instruction uses rs1 or rs2 equal to last_load_rd:
    - hazard=1 and in_ready=0.
    - If the execute side is free, the stage presents a bubble (out_valid=0).
    - stall_cnt increments by 1, saturating at all-ones.
  - last_load_valid clears the following cycle unless another load transfers.
- Handshake:
  - in_ready = !hazard & (!out_valid | out_ready).
  - Accept when in_valid & in_ready: bundle registered; out_valid=1 the next cycle; latency is 1 cycle.
  - out_valid held with a stable bundle until out_ready.
  - Simultaneous transfer out and accept in: back-to-back, full throughput.
- Flush (synchronous, highest priority):
  - Next edge: out_valid=0 and last_load_valid=0.
  - in_ready=1 during flush; any in_valid that cycle is consumed and discarded.
  - stall_cnt is not affected.
- Reset mid-transfer drops the bundle; no partial state survives.

Test Plan:
- Reset with out_valid=1 held: assert rst asynchronously mid-cycle -> out_valid, bundle and stall_cnt read 0 before the next clk edge.
- Stream add x3,x1,x2 (0x002081B3) then sub (0x402081B3), out_ready=1 -> consecutive out_valid cycles with alu_op 00000 then 01000, rd=3, wb 01, in_ready never drops.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x2 -> one bubble cycle, in_ready=0 for 1 cycle, stall_cnt 0→1, add emitted one cycle later. Repeat with rd=x0 -> no bubble.
- out_ready=0 for 3 cycles with a valid bundle -> bundle stable, in_ready=0; out_ready=1 -> transfer plus new accept in the same cycle.
- mul x3,x1,x2 (0x022081B3): EN_MEXT=1 -> alu_op 10000, illegal=0; EN_MEXT=0 -> illegal=1, reg_wr=0. Opcode 0x7F -> illegal=1.
- flush asserted with a valid held bundle and in_valid=1 -> next cycle out_valid=0, incoming instruction discarded, last_load_valid=0. Force 2^CNT_W load-use stalls -> stall_cnt saturates at all-ones.
